// File: rtl/cdma_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cdma_seq_ctrl
// Brief    : Gold-code spreader/despreader sequencer: seed load, chip pacing,
//            MSB-first byte serialisation and majority decode of RX chips.
// Revision : 1.0  initial release
// ============================================================================
module cdma_seq_ctrl #(
   parameter int unsigned CHIPS_PER_BIT = 31,
   parameter int unsigned CHIP_DIV      = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic [4:0] seed_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       gen_load_o,
   output logic [4:0] gen_seed_o,
   output logic       chip_stb_o,
   output logic       signal_o,
   input  logic       rx_chip_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       busy_o,
   output logic       seed_err_o
);

   localparam logic [7:0] c_div_last = 8'(CHIP_DIV - 1);
   localparam logic [7:0] c_cpb_last = 8'(CHIPS_PER_BIT - 1);
   localparam logic [8:0] c_half     = 9'(CHIPS_PER_BIT / 2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_WAIT   = 2'd2,
      S_SPREAD = 2'd3
   } state_t;

   state_t     r_state;
   logic [7:0] r_byte;
   logic [2:0] r_bit_idx;
   logic [7:0] r_div_cnt;
   logic [7:0] r_chip_cnt;
   logic [7:0] r_ones;
   logic [6:0] r_rx_shift;
   logic       r_stop_pending;

   logic       r_tx_ready;
   logic       r_gen_load;
   logic [4:0] r_gen_seed;
   logic       r_chip_stb;
   logic       r_signal;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_busy;
   logic       r_seed_err;

   logic       w_stb;
   logic       w_stb_next;
   logic       w_bit_end;
   logic       w_bit_dec;
   logic [7:0] w_div_next;
   logic [8:0] w_ones_total;

   always_comb begin
      w_stb        = (r_state == S_SPREAD) && (r_div_cnt == c_div_last);
      w_div_next   = (r_div_cnt == c_div_last) ? 8'd0 : r_div_cnt + 8'd1;
      w_stb_next   = (w_div_next == c_div_last);
      w_bit_end    = w_stb && (r_chip_cnt == c_cpb_last);
      // the chip arriving with the final strobe still counts toward the vote
      w_ones_total = {1'b0, r_ones} + {8'd0, rx_chip_i};
      w_bit_dec    = (w_ones_total > c_half);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state        <= S_IDLE;
         r_byte         <= 8'd0;
         r_bit_idx      <= 3'd0;
         r_div_cnt      <= 8'd0;
         r_chip_cnt     <= 8'd0;
         r_ones         <= 8'd0;
         r_rx_shift     <= 7'd0;
         r_stop_pending <= 1'b0;
         r_tx_ready     <= 1'b0;
         r_gen_load     <= 1'b0;
         r_gen_seed     <= 5'd0;
         r_chip_stb     <= 1'b0;
         r_signal       <= 1'b0;
         r_rx_data      <= 8'd0;
         r_rx_valid     <= 1'b0;
         r_busy         <= 1'b0;
         r_seed_err     <= 1'b0;
      end else begin
         r_gen_load <= 1'b0;
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  if (seed_i == 5'd0) begin
                     r_seed_err <= 1'b1;
                  end else begin
                     r_gen_seed <= seed_i;
                     r_seed_err <= 1'b0;
                     r_gen_load <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (r_stop_pending) begin
                  r_stop_pending <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end else begin
                  r_tx_ready <= 1'b1;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (stop_i || r_stop_pending) begin
                  r_stop_pending <= 1'b0;
                  r_tx_ready     <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end else if (tx_valid_i) begin
                  r_byte     <= tx_data_i;
                  r_bit_idx  <= 3'd7;
                  r_chip_cnt <= 8'd0;
                  r_ones     <= 8'd0;
                  r_div_cnt  <= 8'd0;
                  r_tx_ready <= 1'b0;
                  r_signal   <= tx_data_i[7];
                  r_chip_stb <= (c_div_last == 8'd0);
                  r_state    <= S_SPREAD;
               end
            end
            S_SPREAD: begin
               r_div_cnt  <= w_div_next;
               r_chip_stb <= w_stb_next;
               if (stop_i) begin
                  r_stop_pending <= 1'b1;
               end
               if (w_bit_end) begin
                  r_rx_shift <= {r_rx_shift[5:0], w_bit_dec};
                  r_ones     <= 8'd0;
                  r_chip_cnt <= 8'd0;
                  if (r_bit_idx == 3'd0) begin
                     // reload the seed every byte so the receiver stays chip-aligned
                     r_rx_data  <= {r_rx_shift, w_bit_dec};
                     r_rx_valid <= 1'b1;
                     r_gen_load <= 1'b1;
                     r_signal   <= 1'b0;
                     r_chip_stb <= 1'b0;
                     r_state    <= S_LOAD;
                  end else begin
                     r_bit_idx <= r_bit_idx - 3'd1;
                     r_signal  <= r_byte[r_bit_idx - 3'd1];
                  end
               end else if (w_stb) begin
                  r_ones     <= r_ones + {7'd0, rx_chip_i};
                  r_chip_cnt <= r_chip_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_ready_o = r_tx_ready;
   assign gen_load_o = r_gen_load;
   assign gen_seed_o = r_gen_seed;
   assign chip_stb_o = r_chip_stb;
   assign signal_o   = r_signal;
   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_valid;
   assign busy_o     = r_busy;
   assign seed_err_o = r_seed_err;

endmodule
`default_nettype wire
